rx_anc_sync_seq: RTL and testbench

// Runtime-configurable successor to the fixed RX ANC sync/phase controller. Detects the GPIO sync trigger and runs
// a pre-roll, N capture slots and a tail, pulsing start_rx at the start of each slot. Drives NUM_CH hopped baseband
// NCO phases that step per symbol and advance only on accepted samples. Sits between gpio_ctrl and the freq-shift/LPF chains.

---
 rtl/rx_anc_pkg.sv | 18 +
 rtl/rx_anc_phase_gen.sv | 98 +++++++++
 rtl/rx_anc_sync_seq.sv | 190 +++++++++++++++++++
 tb/tb_rx_anc_sync_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_anc_pkg.sv
// rx_anc_pkg: shared state encoding and power-on configuration
// defaults for the RX ANC sync sequencer.
package rx_anc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SLOT = 3'd2,
    TAIL = 3'd3
  } state_e;

  localparam int DEF_SYNC_LEN  = 8192;
  localparam int DEF_NSIG      = 16384;
  localparam int DEF_START_INC = 512;
  localparam int DEF_DPH_INC   = 4096;
  localparam int DEF_CH_INC    = 16384;

endpackage

// File: rtl/rx_anc_phase_gen.sv
// rx_anc_phase_gen: per-channel hopped NCO phase accumulators
// with sample/symbol counters, stepped by accepted samples.
module rx_anc_phase_gen #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int NUM_CH      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          start,
  input  logic                          adv,
  input  logic [PHASE_WIDTH-1:0]        nsig,
  input  logic [NSYMB_WIDTH-1:0]        nsymb,
  input  logic [PHASE_WIDTH-1:0]        start_inc,
  input  logic [PHASE_WIDTH-1:0]        dph_inc,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] ch_inc,
  output logic [NUM_CH*PHASE_WIDTH-1:0] ph,
  output logic [PHASE_WIDTH-1:0]        ph_inc,
  output logic [NSYMB_WIDTH-1:0]        symb_idx,
  output logic                          sym_start
);

  logic                   armed_q, armed_d;
  logic                   sym_q, sym_d;
  logic [PHASE_WIDTH-1:0] sig_q, sig_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
  logic [PHASE_WIDTH-1:0] ph_q [NUM_CH];
  logic [PHASE_WIDTH-1:0] ph_d [NUM_CH];
  logic                   step;

  // Samples count only inside a sequence, after its first slot start.
  assign step = adv & en & armed_q;

  always_comb begin
    armed_d = en ? armed_q : 1'b0;
    sym_d   = sym_q;
    sig_d   = sig_q;
    inc_d   = inc_q;
    symb_d  = symb_q;
    ph_d    = ph_q;
    if (start) begin
      armed_d = 1'b1;
      sym_d   = 1'b1;
      sig_d   = '0;
      symb_d  = '0;
      inc_d   = start_inc;
      for (int c = 0; c < NUM_CH; c++) ph_d[c] = '0;
    end else if (step) begin
      sym_d = 1'b0;
      if (sig_q == nsig - PHASE_WIDTH'(1)) begin
        sym_d = 1'b1;
        sig_d = '0;
        for (int c = 0; c < NUM_CH; c++) ph_d[c] = '0;
        if (symb_q == nsymb - NSYMB_WIDTH'(1)) begin
          symb_d = '0;
          inc_d  = start_inc;
        end else begin
          symb_d = symb_q + NSYMB_WIDTH'(1);
          inc_d  = inc_q + dph_inc;
        end
      end else begin
        sig_d = sig_q + PHASE_WIDTH'(1);
        for (int c = 0; c < NUM_CH; c++)
          ph_d[c] = ph_q[c]
                  - (inc_q + ch_inc[c*PHASE_WIDTH +: PHASE_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      sym_q   <= 1'b0;
      sig_q   <= '0;
      inc_q   <= '0;
      symb_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) ph_q[c] <= '0;
    end else begin
      armed_q <= armed_d;
      sym_q   <= sym_d;
      sig_q   <= sig_d;
      inc_q   <= inc_d;
      symb_q  <= symb_d;
      for (int c = 0; c < NUM_CH; c++) ph_q[c] <= ph_d[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ph
    assign ph[c*PHASE_WIDTH +: PHASE_WIDTH] = ph_q[c];
  end

  assign ph_inc    = inc_q;
  assign symb_idx  = symb_q;
  assign sym_start = sym_q;

endmodule

// File: rtl/rx_anc_sync_seq.sv
// rx_anc_sync_seq: trigger-driven pre-roll/slot/tail sequencer
// with a per-sequence config latch and hopped NCO phases.
module rx_anc_sync_seq
  import rx_anc_pkg::*;
#(
  parameter int PHASE_WIDTH    = 24,
  parameter int NSYMB_WIDTH    = 16,
  parameter int NUM_CH         = 2,
  parameter int NSLOT_WIDTH    = 3,
  parameter int SYNC_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trig,
  input  logic                          abort,
  input  logic [NSLOT_WIDTH-1:0]        cfg_nslots,
  input  logic [SYNC_CNT_WIDTH-1:0]     cfg_sync_len,
  input  logic [PHASE_WIDTH-1:0]        cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0]        cfg_nsymb,
  input  logic [PHASE_WIDTH-1:0]        cfg_start_inc,
  input  logic [PHASE_WIDTH-1:0]        cfg_dph_inc,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] cfg_ch_inc,
  input  logic                          adv,
  output logic [NUM_CH*PHASE_WIDTH-1:0] ph,
  output logic [PHASE_WIDTH-1:0]        ph_inc,
  output logic [NSYMB_WIDTH-1:0]        symb_idx,
  output logic                          sym_start,
  output logic                          start_rx,
  output logic                          sync_en,
  output logic                          valid_rx,
  output logic [NSLOT_WIDTH-1:0]        slot_idx,
  output logic                          done,
  output logic [2:0]                    state
);

  localparam int CHW = NUM_CH * PHASE_WIDTH;

  state_e                    state_q, state_d;
  logic [SYNC_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NSLOT_WIDTH-1:0]    slot_q, slot_d;
  logic                      start_q, start_d;
  logic                      done_q, done_d;
  logic                      trig_q;
  logic                      trig_edge, cnt_last, active;

  logic [NSLOT_WIDTH-1:0]    nslots_q, nslots_d;
  logic [SYNC_CNT_WIDTH-1:0] len_q, len_d;
  logic [PHASE_WIDTH-1:0]    nsig_q, nsig_d;
  logic [NSYMB_WIDTH-1:0]    nsymb_q, nsymb_d;
  logic [PHASE_WIDTH-1:0]    sinc_q, sinc_d;
  logic [PHASE_WIDTH-1:0]    dph_q, dph_d;
  logic [CHW-1:0]            chinc_q, chinc_d;

  assign trig_edge = trig & ~trig_q;
  assign cnt_last  = cnt_q == len_q - SYNC_CNT_WIDTH'(1);
  assign active    = state_q != IDLE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    nslots_d = nslots_q;
    len_d    = len_q;
    nsig_d   = nsig_q;
    nsymb_d  = nsymb_q;
    sinc_d   = sinc_q;
    dph_d    = dph_q;
    chinc_d  = chinc_q;
    unique case (state_q)
      IDLE: begin
        if (trig_edge && !abort) begin
          state_d  = PRE;
          cnt_d    = '0;
          slot_d   = '0;
          // Zero-valued counts are promoted to one.
          nslots_d = (cfg_nslots == '0) ?
                     NSLOT_WIDTH'(1) : cfg_nslots;
          len_d    = (cfg_sync_len == '0) ?
                     SYNC_CNT_WIDTH'(1) : cfg_sync_len;
          nsig_d   = (cfg_nsig == '0) ?
                     PHASE_WIDTH'(1) : cfg_nsig;
          nsymb_d  = (cfg_nsymb == '0) ?
                     NSYMB_WIDTH'(1) : cfg_nsymb;
          sinc_d   = cfg_start_inc;
          dph_d    = cfg_dph_inc;
          chinc_d  = cfg_ch_inc;
        end
      end
      PRE: begin
        cnt_d = cnt_q + SYNC_CNT_WIDTH'(1);
        if (cnt_last) begin
          state_d = SLOT;
          cnt_d   = '0;
          slot_d  = '0;
          start_d = 1'b1;
        end
      end
      SLOT: begin
        cnt_d = cnt_q + SYNC_CNT_WIDTH'(1);
        if (cnt_last) begin
          cnt_d = '0;
          if (slot_q < nslots_q - NSLOT_WIDTH'(1)) begin
            slot_d  = slot_q + NSLOT_WIDTH'(1);
            start_d = 1'b1;
          end else begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        cnt_d = cnt_q + SYNC_CNT_WIDTH'(1);
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && active) begin
      state_d = IDLE;
      cnt_d   = '0;
      start_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
      nslots_q <= '0;
      len_q    <= '0;
      nsig_q   <= '0;
      nsymb_q  <= '0;
      sinc_q   <= '0;
      dph_q    <= '0;
      chinc_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      start_q  <= start_d;
      done_q   <= done_d;
      trig_q   <= trig;
      nslots_q <= nslots_d;
      len_q    <= len_d;
      nsig_q   <= nsig_d;
      nsymb_q  <= nsymb_d;
      sinc_q   <= sinc_d;
      dph_q    <= dph_d;
      chinc_q  <= chinc_d;
    end
  end

  rx_anc_phase_gen #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .NSYMB_WIDTH (NSYMB_WIDTH),
    .NUM_CH      (NUM_CH)
  ) u_phase (
    .clk       (clk),
    .reset     (reset),
    .en        (active),
    .start     (start_q),
    .adv       (adv),
    .nsig      (nsig_q),
    .nsymb     (nsymb_q),
    .start_inc (sinc_q),
    .dph_inc   (dph_q),
    .ch_inc    (chinc_q),
    .ph        (ph),
    .ph_inc    (ph_inc),
    .symb_idx  (symb_idx),
    .sym_start (sym_start)
  );

  assign start_rx = start_q;
  assign done     = done_q;
  assign slot_idx = slot_q;
  assign sync_en  = active;
  assign valid_rx = active;
  assign state    = state_q;

endmodule

// File: tb/tb_rx_anc_sync_seq.sv
// tb_rx_anc_sync_seq: scoreboard bench; slot/done events and
// phase expectations are queued at drive time, popped at output.
module tb_rx_anc_sync_seq;

  localparam int PW = 24;
  localparam int NW = 16;
  localparam int NC = 2;
  localparam int SW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset, trig, abort, adv;
  logic [SW-1:0]    cfg_nslots;
  logic [CW-1:0]    cfg_sync_len;
  logic [PW-1:0]    cfg_nsig, cfg_start_inc, cfg_dph_inc;
  logic [NW-1:0]    cfg_nsymb;
  logic [NC*PW-1:0] cfg_ch_inc;
  logic [NC*PW-1:0] ph;
  logic [PW-1:0]    ph_inc;
  logic [NW-1:0]    symb_idx;
  logic             sym_start, start_rx, sync_en, valid_rx, done;
  logic [SW-1:0]    slot_idx;
  logic [2:0]       state;

  rx_anc_sync_seq dut (
    .clk(clk), .reset(reset), .trig(trig), .abort(abort),
    .cfg_nslots(cfg_nslots), .cfg_sync_len(cfg_sync_len),
    .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb),
    .cfg_start_inc(cfg_start_inc), .cfg_dph_inc(cfg_dph_inc),
    .cfg_ch_inc(cfg_ch_inc), .adv(adv),
    .ph(ph), .ph_inc(ph_inc), .symb_idx(symb_idx),
    .sym_start(sym_start), .start_rx(start_rx),
    .sync_en(sync_en), .valid_rx(valid_rx),
    .slot_idx(slot_idx), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int cyc;
    int slot;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [PW-1:0] p0, p1, inc;
    logic [NW-1:0] sy;
    logic          ss;
  } ph_t;

  ev_t start_sb[$];
  int  done_sb[$];
  ph_t ph_sb[$];
  int  sync_lo = 0;
  int  sync_hi = 0;
  bit  mon_on  = 0;

  // Reference phase model, stepped once per clock by the driver.
  logic [PW-1:0] m_ph [NC];
  logic [PW-1:0] m_inc, m_sig;
  logic [NW-1:0] m_sy;
  bit            m_ss, m_arm;
  logic [PW-1:0] l_nsig, l_start, l_dph;
  logic [NW-1:0] l_nsymb;
  logic [PW-1:0] l_ch [NC];

  task automatic m_step(input bit st, input bit a);
    if (st) begin
      m_arm = 1; m_ss = 1;
      m_sig = '0; m_sy = '0; m_inc = l_start;
      for (int i = 0; i < NC; i++) m_ph[i] = '0;
    end else if (a && m_arm) begin
      m_ss = 0;
      if (m_sig == l_nsig - 24'd1) begin
        m_sig = '0; m_ss = 1;
        for (int i = 0; i < NC; i++) m_ph[i] = '0;
        if (m_sy == l_nsymb - 16'd1) begin
          m_sy = '0; m_inc = l_start;
        end else begin
          m_sy = m_sy + 16'd1; m_inc = m_inc + l_dph;
        end
      end else begin
        m_sig = m_sig + 24'd1;
        for (int i = 0; i < NC; i++)
          m_ph[i] = m_ph[i] - (m_inc + l_ch[i]);
      end
    end
  endtask

  task automatic push_ph(input int c);
    ph_t e;
    e.cyc = c; e.p0 = m_ph[0]; e.p1 = m_ph[1];
    e.inc = m_inc; e.sy = m_sy; e.ss = m_ss;
    ph_sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      ev_t e;
      ph_t p;
      chk("sync_en", sync_en, (cyc >= sync_lo && cyc < sync_hi));
      chk("valid_rx", valid_rx, (cyc >= sync_lo && cyc < sync_hi));
      while (start_sb.size() > 0 && start_sb[0].cyc < cyc) begin
        e = start_sb.pop_front();
        chk("start_rx_missed", cyc, e.cyc);
      end
      if (start_rx) begin
        if (start_sb.size() == 0) begin
          chk("start_rx_unexpected", start_rx, 1'b0);
        end else begin
          e = start_sb.pop_front();
          chk("start_rx_cyc", cyc, e.cyc);
          chk("slot_idx", slot_idx, e.slot);
        end
      end
      while (done_sb.size() > 0 && done_sb[0] < cyc)
        chk("done_missed", cyc, done_sb.pop_front());
      if (done) begin
        if (done_sb.size() == 0) chk("done_unexpected", done, 1'b0);
        else chk("done_cyc", cyc, done_sb.pop_front());
      end
      while (ph_sb.size() > 0 && ph_sb[0].cyc < cyc)
        chk("ph_stale", cyc, ph_sb.pop_front().cyc);
      if (ph_sb.size() > 0 && ph_sb[0].cyc == cyc) begin
        p = ph_sb.pop_front();
        chk("ph0", ph[PW-1:0], p.p0);
        chk("ph1", ph[2*PW-1:PW], p.p1);
        chk("ph_inc", ph_inc, p.inc);
        chk("symb_idx", symb_idx, p.sy);
        chk("sym_start", sym_start, p.ss);
      end
    end
  end

  task automatic set_cfg(input int ns, input int len,
                         input int nsig, input int nsymb,
                         input int si, input int dph,
                         input int c0, input int c1);
    cfg_nslots = SW'(ns); cfg_sync_len = CW'(len);
    cfg_nsig = PW'(nsig); cfg_nsymb = NW'(nsymb);
    cfg_start_inc = PW'(si); cfg_dph_inc = PW'(dph);
    cfg_ch_inc = {PW'(c1), PW'(c0)};
    l_nsig = (nsig == 0) ? 24'd1 : PW'(nsig);
    l_nsymb = (nsymb == 0) ? 16'd1 : NW'(nsymb);
    l_start = PW'(si); l_dph = PW'(dph);
    l_ch[0] = PW'(c0); l_ch[1] = PW'(c1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ph"}, ph, '0);
    chk({tag, "_ph_inc"}, ph_inc, '0);
    chk({tag, "_symb"}, symb_idx, '0);
    chk({tag, "_sym_start"}, sym_start, 1'b0);
    chk({tag, "_start_rx"}, start_rx, 1'b0);
    chk({tag, "_sync_en"}, sync_en, 1'b0);
    chk({tag, "_valid_rx"}, valid_rx, 1'b0);
    chk({tag, "_slot"}, slot_idx, '0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_state"}, state, 3'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, hi;
    reset = 1; trig = 0; abort = 0; adv = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    m_arm = 0; m_ss = 0; m_inc = '0; m_sig = '0; m_sy = '0;
    for (int i = 0; i < NC; i++) m_ph[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;
    mon_on = 1;

    // Sequence A: 2 slots of 8, config disturbed mid-run.
    set_cfg(2, 8, 5, 2, 300, 7, 1, 2);
    wait_cyc(10);
    t = cyc; trig = 1;
    start_sb.push_back('{t + 9, 0});
    start_sb.push_back('{t + 17, 1});
    done_sb.push_back(t + 33);
    sync_lo = t + 1; sync_hi = t + 33;
    wait_cyc(t + 1); chk("A_state_pre", state, 3'd1);
    wait_cyc(t + 5);
    cfg_sync_len = 16'd3; cfg_nslots = 3'd5;
    wait_cyc(t + 9); chk("A_state_slot", state, 3'd2);
    wait_cyc(t + 25); chk("A_state_tail", state, 3'd3);
    wait_cyc(t + 33); chk("A_state_idle", state, 3'd0);
    m_step(1, 0);
    m_arm = 0;
    // Level held high must not retrigger.
    wait_cyc(t + 133);
    trig = 0;
    wait_cyc(t + 140);

    // Sequence B: phase stepping, second start over a live adv.
    set_cfg(2, 20, 4, 3, 100, 50, 0, 10);
    t = cyc; trig = 1;
    s = t + 21;
    start_sb.push_back('{s, 0});
    start_sb.push_back('{s + 20, 1});
    done_sb.push_back(t + 81);
    sync_lo = t + 1; sync_hi = t + 81;
    for (int c = t; c <= t + 90; c++) begin
      bit in_seq;
      wait_cyc(c);
      if (c == t + 3) trig = 0;
      adv = (c >= t + 2) && ((c - s < 30) || (c % 3 != 0));
      if (c == s + 2) chk("B_ph1_first", ph[2*PW-1:PW], 24'hFFFF92);
      if (c == s + 4) chk("B_ph0_third", ph[PW-1:0], 24'hFFFED4);
      if (c == s + 13) chk("B_inc_wrap", ph_inc, 24'd100);
      if (c == s + 5) begin
        cfg_start_inc = 24'd777; cfg_dph_inc = 24'd3;
        cfg_nsig = 24'd9; cfg_ch_inc = '1;
      end
      in_seq = (c >= t + 1) && (c < t + 81);
      if (!in_seq) m_arm = 0;
      m_step((c == s) || (c == s + 20), adv && in_seq);
      push_ph(c + 1);
    end
    adv = 0;
    wait_cyc(t + 95);

    // Sequence C: abort in slot 0 at cnt=3.
    set_cfg(3, 8, 4, 3, 100, 50, 0, 10);
    t = cyc; trig = 1;
    s = t + 9;
    start_sb.push_back('{s, 0});
    sync_lo = t + 1; sync_hi = s + 4;
    wait_cyc(t + 2); trig = 0;
    wait_cyc(s + 3); abort = 1;
    wait_cyc(s + 4); abort = 0;
    chk("C_state_abort", state, 3'd0);
    wait_cyc(s + 40);

    // Sequence D: reset asserted during the tail.
    set_cfg(1, 4, 4, 3, 100, 50, 0, 10);
    t = cyc; trig = 1;
    start_sb.push_back('{t + 5, 0});
    sync_lo = t + 1; sync_hi = t + 11;
    wait_cyc(t + 2); trig = 0;
    wait_cyc(t + 10);
    chk("D_state_tail", state, 3'd3);
    reset = 1;
    wait_cyc(t + 11);
    chk_zero("D_reset");
    reset = 0;
    wait_cyc(t + 30);

    // Sequence E: zero counts promote to one slot of one cycle.
    set_cfg(0, 0, 0, 0, 5, 5, 0, 0);
    t = cyc; trig = 1;
    start_sb.push_back('{t + 2, 0});
    done_sb.push_back(t + 4);
    sync_lo = t + 1; sync_hi = t + 4;
    wait_cyc(t + 2); trig = 0;
    hi = t + 12;
    wait_cyc(hi);

    chk("start_left", start_sb.size(), 0);
    chk("done_left", done_sb.size(), 0);
    chk("ph_left", ph_sb.size(), 0);
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
